// File: rtl/i2s_receiver_if.sv
// i2s_receiver_if: bus bundle between the I2S pin/enable side and the receiver.
//   sck, ws, sd   : I2S bit clock, word select (0=left, 1=right), serial data
//   rx_en         : receive enable from the ws-framing checker
//   data_left/right : last complete left/right word, DW bits, MSB-justified
//   valid_left/right: one-cycle update strobes (only with I2S_RX_VALID_EN)
// modport slave  = receiver side, modport master = driver/observer side.
interface i2s_receiver_if #(parameter int DW = 32);
   logic          sck;
   logic          ws;
   logic          sd;
   logic          rx_en;
   logic [DW-1:0] data_left;
   logic [DW-1:0] data_right;
`ifdef I2S_RX_VALID_EN
   logic          valid_left;
   logic          valid_right;

   modport master (output sck, ws, sd, rx_en,
                   input  data_left, data_right, valid_left, valid_right);
   modport slave  (input  sck, ws, sd, rx_en,
                   output data_left, data_right, valid_left, valid_right);
`else
   modport master (output sck, ws, sd, rx_en,
                   input  data_left, data_right);
   modport slave  (input  sck, ws, sd, rx_en,
                   output data_left, data_right);
`endif
endinterface

// File: rtl/i2s_receiver.sv
// i2s_receiver: Philips-format I2S receiver, oversampled in the clk domain.
// Deserialises MSB-first stereo words into data_left / data_right.
//   clk  : system clock (>= 2x sck), rising edge
//   rst  : synchronous active-high reset, priority over rx_en
//   bus  : i2s_receiver_if.slave (sck, ws, sd, rx_en in; data_left,
//          data_right out; valid_left/valid_right when enabled)
// Optional feature macro: I2S_RX_VALID_EN adds one-cycle valid strobes that
// coincide with each data register update.
module i2s_receiver #(
   parameter int DW = 32
) (
   input  logic          clk,
   input  logic          rst,
   i2s_receiver_if.slave bus
);

   typedef enum logic {UNSYNC, RUN} state_t;

   state_t        state_q, state_d;
   logic          sck_q1, sck_q2, ws_q1, sd_q1, ws_prev;
   logic [5:0]    cnt_q, cnt_d;
   logic [DW-1:0] shift_q, shift_d, merged;
   logic          sck_rise, wr_left, wr_right;

   // sck is sampled as data; falling edges are never used
   assign sck_rise = sck_q1 & ~sck_q2;

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      shift_d  = shift_q;
      wr_left  = 1'b0;
      wr_right = 1'b0;
      // current bit merged at position DW-1-cnt; bits with cnt >= DW match
      // no position and fall away
      merged   = shift_q;
      for (int i = 0; i < DW; i++)
         if (cnt_q == 6'(DW-1-i)) merged[i] = sd_q1;

      if (!bus.rx_en) begin
         state_d = UNSYNC;
         cnt_d   = '0;
         shift_d = '0;
      end else if (sck_rise) begin
         case (state_q)
            UNSYNC: begin
               // ws fall: this bit closes a partial right word (discarded),
               // the next bit is the MSB of a complete left word
               if (ws_prev && !ws_q1) begin
                  state_d = RUN;
                  cnt_d   = '0;
                  shift_d = '0;
               end
            end
            RUN: begin
               if (ws_q1 != ws_prev) begin
                  // one-bit delay: this bit is the LSB of the ending word
                  wr_left  = ~ws_prev;
                  wr_right = ws_prev;
                  cnt_d    = '0;
                  shift_d  = '0;
               end else begin
                  shift_d = merged;
                  // saturate so an overlong word never wraps back into range
                  if (cnt_q != 6'h3f) cnt_d = cnt_q + 6'd1;
               end
            end
            default: state_d = UNSYNC;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         sck_q1         <= 1'b0;
         sck_q2         <= 1'b0;
         ws_q1          <= 1'b0;
         sd_q1          <= 1'b0;
         ws_prev        <= 1'b0;
         state_q        <= UNSYNC;
         cnt_q          <= '0;
         shift_q        <= '0;
         bus.data_left  <= '0;
         bus.data_right <= '0;
      end else begin
         sck_q1  <= bus.sck;
         sck_q2  <= sck_q1;
         ws_q1   <= bus.ws;
         sd_q1   <= bus.sd;
         // ws history tracks even while disabled so a re-enable can sync
         // on the very next ws fall
         if (sck_rise) ws_prev <= ws_q1;
         state_q <= state_d;
         cnt_q   <= cnt_d;
         shift_q <= shift_d;
         if (wr_left)  bus.data_left  <= merged;
         if (wr_right) bus.data_right <= merged;
      end
   end

`ifdef I2S_RX_VALID_EN
   always_ff @(posedge clk) begin
      if (rst) begin
         bus.valid_left  <= 1'b0;
         bus.valid_right <= 1'b0;
      end else begin
         bus.valid_left  <= wr_left;
         bus.valid_right <= wr_right;
      end
   end
`endif

endmodule

// File: tb/tb_i2s_receiver.sv
// tb_i2s_receiver: directed bench for i2s_receiver. sck runs at clk/2 and
// ws/sd change together with sck rising, all edge-aligned to clk.
module tb_i2s_receiver;

   logic clk;
   logic rst;
   int   checks;
   int   errors;
   int   exp_frames;
   int   vl_cnt;
   int   vr_cnt;

   i2s_receiver_if #(.DW(32)) bus ();

   i2s_receiver #(.DW(32)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      vl_cnt = 0;
      vr_cnt = 0;
   end
`ifdef I2S_RX_VALID_EN
   always @(posedge clk) begin
      if (bus.valid_left)  vl_cnt = vl_cnt + 1;
      if (bus.valid_right) vr_cnt = vr_cnt + 1;
   end
`endif

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks = checks + 1;
      if (got !== exp) begin
         errors = errors + 1;
         $display("FAIL %s got=%08h exp=%08h", tag, got, exp);
      end
   endtask

   task automatic send_bit(input logic w, input logic d);
      @(posedge clk); #1;
      bus.sck = 1'b1;
      bus.ws  = w;
      bus.sd  = d;
      @(posedge clk); #1;
      bus.sck = 1'b0;
   endtask

   // ch=0 left, ch=1 right; ws flips on the word's LSB (one-bit delay)
   task automatic send_word(input logic [31:0] v, input int nb, input logic ch);
      for (int i = 0; i < nb; i++)
         send_bit((i == nb-1) ? ~ch : ch, v[31-i]);
   endtask

   task automatic send_frame(input logic [31:0] l, input logic [31:0] r, input int nb);
      send_word(l, nb, 1'b0);
      send_word(r, nb, 1'b1);
      repeat (2) @(posedge clk);
      #1;
      exp_frames = exp_frames + 1;
   endtask

   task automatic send_run(input logic w, input int n);
      for (int i = 0; i < n; i++) send_bit(w, 1'b1);
   endtask

   logic [31:0] l_rnd, r_rnd;

   initial begin
      checks     = 0;
      errors     = 0;
      exp_frames = 0;
      rst        = 1'b1;
      bus.sck    = 1'b0;
      bus.ws     = 1'b0;
      bus.sd     = 1'b0;
      bus.rx_en  = 1'b0;

      // reset for 10 sck periods
      repeat (20) @(posedge clk);
      #1;
      chk("rst_left",  bus.data_left,  32'h0);
      chk("rst_right", bus.data_right, 32'h0);
      rst       = 1'b0;
      bus.rx_en = 1'b1;

      // sync: ws high for a few bits, then the ws fall
      send_run(1'b1, 3);
      send_bit(1'b0, 1'b1);
      send_frame(32'h0, 32'h0, 32);
      chk("zero_left",  bus.data_left,  32'h0);
      chk("zero_right", bus.data_right, 32'h0);

      send_frame(32'h8000_0001, 32'h7FFF_FFFE, 32);
      chk("edge_left",  bus.data_left,  32'h8000_0001);
      chk("edge_right", bus.data_right, 32'h7FFF_FFFE);

      for (int f = 0; f < 20; f++) begin
         l_rnd = $urandom;
         r_rnd = $urandom;
         send_frame(l_rnd, r_rnd, 32);
         chk("rnd_left",  bus.data_left,  l_rnd);
         chk("rnd_right", bus.data_right, r_rnd);
      end

      // 24-bit slots: MSB-justified, zero-padded
      send_frame(32'hABCD_EF00, 32'h1234_5600, 24);
      chk("s24_left",  bus.data_left,  32'hABCD_EF00);
      chk("s24_right", bus.data_right, 32'h1234_5600);

      // drop rx_en for 3 sck periods mid-word
      send_run(1'b0, 10);
      bus.rx_en = 1'b0;
      send_run(1'b0, 3);
      chk("dis_hold_left",  bus.data_left,  32'hABCD_EF00);
      bus.rx_en = 1'b1;
      send_run(1'b0, 18);
      send_bit(1'b1, 1'b1);          // ws rise while unsynced: ignored
      send_run(1'b1, 31);
      send_bit(1'b0, 1'b1);          // ws fall: resync, partial word dropped
      repeat (2) @(posedge clk);
      #1;
      chk("resync_left",  bus.data_left,  32'hABCD_EF00);
      chk("resync_right", bus.data_right, 32'h1234_5600);
      send_frame(32'h1357_9BDF, 32'h2468_ACE0, 32);
      chk("reen_left",  bus.data_left,  32'h1357_9BDF);
      chk("reen_right", bus.data_right, 32'h2468_ACE0);

      // rst mid-frame
      send_run(1'b0, 16);
      @(posedge clk); #1;
      rst = 1'b1;
      @(posedge clk); #1;
      chk("mrst_left",  bus.data_left,  32'h0);
      chk("mrst_right", bus.data_right, 32'h0);
      rst = 1'b0;
      send_run(1'b0, 15);
      send_bit(1'b1, 1'b1);
      send_run(1'b1, 31);
      send_bit(1'b0, 1'b1);
      repeat (2) @(posedge clk);
      #1;
      chk("post_rst_left",  bus.data_left,  32'h0);
      chk("post_rst_right", bus.data_right, 32'h0);
      send_frame(32'hCAFE_F00D, 32'h0BAD_BEEF, 32);
      chk("post_rst_fr_left",  bus.data_left,  32'hCAFE_F00D);
      chk("post_rst_fr_right", bus.data_right, 32'h0BAD_BEEF);

`ifdef I2S_RX_VALID_EN
      chk("valid_left_cnt",  32'(vl_cnt), 32'(exp_frames));
      chk("valid_right_cnt", 32'(vr_cnt), 32'(exp_frames));
`endif

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
